// File: rtl/conv_window_sched.sv
// Convolution window scheduler: accepts one window from the line buffer and issues it as
// NUM_FILTERS MAC jobs. Define SCHED_PERF_CNT_EN to enable the mac_stall_cnt counter.
module conv_window_sched #(
  parameter int OUT_WIDTH   = 6,
  parameter int OUT_HEIGHT  = 6,
  parameter int NUM_FILTERS = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 8,
  localparam int WIN_W = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE * CHANNELS,
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int RW    = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1,
  localparam int CW    = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_win_valid,
  output logic             o_win_ready,
  input  logic [WIN_W-1:0] i_win_data,
  output logic             o_mac_valid,
  input  logic             i_mac_ready,
  output logic [WIN_W-1:0] o_mac_data,
  output logic [FW-1:0]    o_mac_filter_idx,
  output logic             o_mac_last,
  output logic [RW-1:0]    o_out_row,
  output logic [CW-1:0]    o_out_col,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [31:0]      o_mac_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WIN,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WIN_W-1:0]  r_mac_data;
  logic [FW-1:0]     r_idx;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;

  logic w_start_acc;
  logic w_win_xfer;
  logic w_mac_xfer;
  logic w_idx_last;
  logic w_col_last;
  logic w_row_last;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_win_xfer  = (r_state == S_WAIT_WIN) && i_win_valid;
  assign w_mac_xfer  = (r_state == S_ISSUE) && i_mac_ready;
  assign w_idx_last  = (r_idx == FW'(NUM_FILTERS - 1));
  assign w_col_last  = (r_col == CW'(OUT_WIDTH - 1));
  assign w_row_last  = (r_row == RW'(OUT_HEIGHT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next_state = S_WAIT_WIN;
      S_WAIT_WIN: if (i_win_valid) w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (i_mac_ready && w_idx_last) begin
          w_next_state = (w_col_last && w_row_last) ? S_DONE : S_WAIT_WIN;
        end
      end
      S_DONE:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_win_ready  = (r_state == S_WAIT_WIN);
    o_mac_valid  = (r_state == S_ISSUE);
    o_mac_last   = (r_state == S_ISSUE) && w_idx_last;
    o_busy       = (r_state != S_IDLE);
    o_frame_done = (r_state == S_DONE);
  end

  // Position wraps to (0,0) on the final job, so it is already clear on entering DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mac_data <= '0;
      r_idx      <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      if (w_start_acc) begin
        r_idx <= '0;
        r_row <= '0;
        r_col <= '0;
      end
      if (w_win_xfer) begin
        r_mac_data <= i_win_data;
      end
      if (w_mac_xfer) begin
        if (w_idx_last) begin
          r_idx <= '0;
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end else begin
          r_idx <= r_idx + FW'(1);
        end
      end
    end
  end

  assign o_mac_data       = r_mac_data;
  assign o_mac_filter_idx = r_idx;
  assign o_out_row        = r_row;
  assign o_out_col        = r_col;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_ISSUE) && !i_mac_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_mac_stall_cnt = r_stall_cnt;
`else
  assign o_mac_stall_cnt = 32'd0;
`endif

endmodule
